// File: rtl/div_cnt_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div_pkg                                                        |
// | Purpose  : Shared definitions for the shared divide-counter arbiter:      |
// |            default widths, FSM state encoding and the clamping helpers    |
// |            that turn raw ratio/burst settings into effective values.      |
// | Ports    : none (package)                                                 |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package div_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int DIV_W_DEF   = 4;
  localparam int BURST_W_DEF = 4;

  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_RUN  = 2'd1;
  localparam logic [1:0] C_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = C_ST_IDLE,
    ST_RUN  = C_ST_RUN,
    ST_DONE = C_ST_DONE
  } state_t;

  // A period of 0 or 1 both mean "tick every cycle".
  function automatic logic [31:0] eff_period(input logic [31:0] p);
    return (p < 32'd2) ? 32'd1 : p;
  endfunction

  // A zero burst still delivers one tick so a grant always completes.
  function automatic logic [31:0] eff_burst(input logic [31:0] b);
    return (b == 32'd0) ? 32'd1 : b;
  endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_cnt_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div_cnt_arb_if                                                 |
// | Purpose  : Bundle between the requesting clients and the shared divide    |
// |            counter.                                                       |
// | Ports    : req, div_ratio, burst_len   client -> counter                  |
// |            gnt, busy, tick, done, po_cnt  counter -> clients              |
// |            modport master = client side, modport slave = counter side     |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface div_cnt_arb_if
  import div_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
);

  logic [NREQ-1:0]         req;
  logic [NREQ*DIV_W-1:0]   div_ratio;
  logic [NREQ*BURST_W-1:0] burst_len;
  logic [NREQ-1:0]         gnt;
  logic                    busy;
  logic                    tick;
  logic                    done;
  logic [DIV_W-1:0]        po_cnt;

  modport master (
    output req, div_ratio, burst_len,
    input  gnt, busy, tick, done, po_cnt
  );

  modport slave (
    input  req, div_ratio, burst_len,
    output gnt, busy, tick, done, po_cnt
  );

endinterface : div_cnt_arb_if
`default_nettype wire

// File: rtl/div_cnt_arb_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arb                                                         |
// | Purpose  : Combinational round-robin pick. Scans req starting at ptr and  |
// |            wrapping; reports the first set requester.                     |
// | Ports    : req   in   NREQ    request vector                              |
// |            ptr   in   IDX_W   highest-priority index                      |
// |            gnt   out  NREQ    one-hot winner (zero if none)               |
// |            idx   out  IDX_W   winner index                                |
// |            valid out  1       any request present                         |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module rr_arb
  import div_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    // First hit wins; later hits are masked by valid.
    for (int k = 0; k < NREQ; k++) begin
      if (!valid && req[(int'(ptr) + k) % NREQ]) begin
        valid                          = 1'b1;
        idx                            = IDX_W'((int'(ptr) + k) % NREQ);
        gnt[(int'(ptr) + k) % NREQ]    = 1'b1;
      end
    end
  end

endmodule : rr_arb
`default_nettype wire

// File: rtl/div_cnt_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div_cnt_arb                                                    |
// | Purpose  : One programmable divide counter shared by NREQ requesters.     |
// |            A round-robin arbiter grants one requester, its period and     |
// |            burst are latched, the counter emits that many ticks, then     |
// |            the grant is released (done) or abandoned (req dropped).       |
// | Ports    : clk   in  system clock, rising edge                            |
// |            rst   in  asynchronous active-high reset                       |
// |            bus   slave modport of div_cnt_arb_if:                         |
// |                  req/div_ratio/burst_len in, gnt/busy/tick/done/po_cnt out|
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module div_cnt_arb
  import div_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  div_cnt_arb_if.slave  bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Per-requester views of the packed configuration buses.
  logic [DIV_W-1:0]   w_ratio [NREQ];
  logic [BURST_W-1:0] w_burst [NREQ];

  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign w_ratio[g] = bus.div_ratio[g*DIV_W +: DIV_W];
      assign w_burst[g] = bus.burst_len[g*BURST_W +: BURST_W];
    end
  endgenerate

  // State and latched grant context.
  state_t             r_state;
  logic [NREQ-1:0]    r_gnt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_ptr;
  logic [DIV_W-1:0]   r_pe;
  logic [BURST_W-1:0] r_be;
  logic [DIV_W-1:0]   r_po_cnt;
  logic [BURST_W-1:0] r_tcnt;
  logic               r_tick;
  logic               r_done;

  // Next-state values.
  state_t             w_state_nxt;
  logic [NREQ-1:0]    w_gnt_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [DIV_W-1:0]   w_pe_nxt;
  logic [BURST_W-1:0] w_be_nxt;
  logic [DIV_W-1:0]   w_po_nxt;
  logic [BURST_W-1:0] w_tcnt_nxt;
  logic               w_tick_nxt;
  logic               w_done_nxt;

  // Arbiter results.
  logic [NREQ-1:0]    w_arb_gnt;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_valid;

  logic [DIV_W-1:0]   w_sel_pe;
  logic [BURST_W-1:0] w_sel_be;
  logic [IDX_W-1:0]   w_ptr_after;
  logic               w_req_held;
  logic               w_period_end;
  logic               w_last_tick;

  rr_arb #(
    .NREQ (NREQ)
  ) u_rr_arb (
    .req   (bus.req),
    .ptr   (r_ptr),
    .gnt   (w_arb_gnt),
    .idx   (w_arb_idx),
    .valid (w_arb_valid)
  );

  assign w_sel_pe     = DIV_W'(eff_period(32'(w_ratio[w_arb_idx])));
  assign w_sel_be     = BURST_W'(eff_burst(32'(w_burst[w_arb_idx])));
  assign w_ptr_after  = (r_idx == IDX_W'(NREQ - 1)) ? '0 : r_idx + IDX_W'(1);
  assign w_req_held   = |(bus.req & r_gnt);
  assign w_period_end = (r_po_cnt == r_pe - DIV_W'(1));
  // Checking tcnt against Be-1 before incrementing keeps tcnt from wrapping.
  assign w_last_tick  = w_period_end && (r_tcnt == r_be - BURST_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_pe_nxt    = r_pe;
    w_be_nxt    = r_be;
    w_po_nxt    = r_po_cnt;
    w_tcnt_nxt  = r_tcnt;

    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt = ST_RUN;
          w_gnt_nxt   = w_arb_gnt;
          w_idx_nxt   = w_arb_idx;
          w_pe_nxt    = w_sel_pe;
          w_be_nxt    = w_sel_be;
          w_po_nxt    = '0;
          w_tcnt_nxt  = '0;
        end
      end
      ST_RUN: begin
        // Completion outranks an abandon arriving on the final tick.
        if (w_last_tick) begin
          w_state_nxt = ST_DONE;
          w_po_nxt    = '0;
          w_tcnt_nxt  = '0;
        end else if (!w_req_held) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_po_nxt    = '0;
          w_tcnt_nxt  = '0;
          w_ptr_nxt   = w_ptr_after;
        end else if (w_period_end) begin
          w_po_nxt    = '0;
          w_tcnt_nxt  = r_tcnt + BURST_W'(1);
        end else begin
          w_po_nxt    = r_po_cnt + DIV_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_po_nxt    = '0;
        w_ptr_nxt   = w_ptr_after;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_po_nxt    = '0;
        w_tcnt_nxt  = '0;
      end
    endcase

    // tick/done are registered: predict them from the next-cycle state so
    // tick lines up with the cycle in which po_cnt shows Pe-1.
    w_tick_nxt = (w_state_nxt == ST_RUN) && (w_po_nxt == w_pe_nxt - DIV_W'(1));
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_idx    <= '0;
      r_ptr    <= '0;
      r_pe     <= DIV_W'(1);
      r_be     <= BURST_W'(1);
      r_po_cnt <= '0;
      r_tcnt   <= '0;
      r_tick   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_idx    <= w_idx_nxt;
      r_ptr    <= w_ptr_nxt;
      r_pe     <= w_pe_nxt;
      r_be     <= w_be_nxt;
      r_po_cnt <= w_po_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_tick   <= w_tick_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.tick   = r_tick;
  assign bus.done   = r_done;
  assign bus.po_cnt = r_po_cnt;

endmodule : div_cnt_arb
`default_nettype wire

// File: tb/tb_div_cnt_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_div_cnt_arb                                                 |
// | Purpose  : Directed self-checking bench for div_cnt_arb. Inputs change    |
// |            on the falling edge, outputs are sampled on the falling edge.  |
// | Ports    : none                                                           |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_div_cnt_arb;

  localparam int NREQ    = 4;
  localparam int DIV_W   = 4;
  localparam int BURST_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_cnt_arb_if #(.NREQ(NREQ), .DIV_W(DIV_W), .BURST_W(BURST_W)) bus ();

  div_cnt_arb #(
    .NREQ    (NREQ),
    .DIV_W   (DIV_W),
    .BURST_W (BURST_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int i, input int p, input int b);
    bus.div_ratio[i*DIV_W +: DIV_W]     = DIV_W'(p);
    bus.burst_len[i*BURST_W +: BURST_W] = BURST_W'(b);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},  32'(bus.gnt),    32'h0);
    chk({tag, "_busy"}, 32'(bus.busy),   32'h0);
    chk({tag, "_tick"}, 32'(bus.tick),   32'h0);
    chk({tag, "_done"}, 32'(bus.done),   32'h0);
    chk({tag, "_po"},   32'(bus.po_cnt), 32'h0);
  endtask

  initial begin
    logic [DIV_W-1:0] exp_po2   [6];
    logic             exp_tick2 [6];
    logic [NREQ-1:0]  exp_g3    [5];
    logic [DIV_W-1:0] exp_po5   [5];
    checks = 0;
    errors = 0;
    exp_po2   = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};
    exp_tick2 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_g3    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_po5   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

    // 1: reset held with no requests
    rst           = 1'b1;
    bus.req       = '0;
    bus.div_ratio = '0;
    bus.burst_len = '0;
    #100;
    cyc();
    chk_idle("t1_rst");
    rst = 1'b0;

    // 2: single requester, P=3 B=2; ratio change mid-run must be ignored
    cyc();
    set_cfg(0, 3, 2);
    bus.req = 4'b0001;
    cyc();
    chk("t2_gnt", 32'(bus.gnt), 32'h1);
    chk("t2_busy", 32'(bus.busy), 32'h1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      chk($sformatf("t2_po%0d", i), 32'(bus.po_cnt), 32'(exp_po2[i]));
      chk($sformatf("t2_tick%0d", i), 32'(bus.tick), 32'(exp_tick2[i]));
      chk($sformatf("t2_done%0d", i), 32'(bus.done), 32'h0);
      if (i == 1) set_cfg(0, 7, 9);
    end
    cyc();
    chk("t2_done", 32'(bus.done), 32'h1);
    chk("t2_done_gnt", 32'(bus.gnt), 32'h1);
    chk("t2_done_tick", 32'(bus.tick), 32'h0);
    bus.req = '0;
    cyc();
    chk_idle("t2_after");

    // 3: reset pointer, all four requesting P=2 B=1: strict rotation
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_cfg(i, 2, 1);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("t3_gnt%0d", k), 32'(bus.gnt), 32'(exp_g3[k]));
      chk($sformatf("t3_tick0_%0d", k), 32'(bus.tick), 32'h0);
      cyc();
      chk($sformatf("t3_tick1_%0d", k), 32'(bus.tick), 32'h1);
      cyc();
      chk($sformatf("t3_done%0d", k), 32'(bus.done), 32'h1);
      chk($sformatf("t3_dgnt%0d", k), 32'(bus.gnt), 32'(exp_g3[k]));
      cyc();
      chk($sformatf("t3_dead_gnt%0d", k), 32'(bus.gnt), 32'h0);
      chk($sformatf("t3_dead_busy%0d", k), 32'(bus.busy), 32'h0);
    end
    bus.req = '0;

    // 4: degenerate settings P=0/P=1 with B=0 give one tick, then done
    cyc();
    set_cfg(0, 0, 0);
    set_cfg(1, 1, 0);
    bus.req = 4'b0011;
    cyc();
    chk("t4_gnt_a", 32'(bus.gnt), 32'h2);
    chk("t4_tick_a", 32'(bus.tick), 32'h1);
    chk("t4_po_a", 32'(bus.po_cnt), 32'h0);
    cyc();
    chk("t4_done_a", 32'(bus.done), 32'h1);
    chk("t4_dtick_a", 32'(bus.tick), 32'h0);
    cyc();
    chk("t4_dead_a", 32'(bus.gnt), 32'h0);
    chk("t4_dtick2_a", 32'(bus.tick), 32'h0);
    cyc();
    chk("t4_gnt_b", 32'(bus.gnt), 32'h1);
    chk("t4_tick_b", 32'(bus.tick), 32'h1);
    cyc();
    chk("t4_done_b", 32'(bus.done), 32'h1);
    chk("t4_dtick_b", 32'(bus.tick), 32'h0);
    cyc();
    chk("t4_dead_b", 32'(bus.gnt), 32'h0);
    bus.req = '0;

    // 5: req0 abandons mid-burst (P=4 B=3), req1 picks up next
    cyc();
    set_cfg(0, 4, 3);
    set_cfg(1, 2, 1);
    bus.req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("t5_gnt%0d", i), 32'(bus.gnt), 32'h1);
      chk($sformatf("t5_po%0d", i), 32'(bus.po_cnt), 32'(exp_po5[i]));
      chk($sformatf("t5_tick%0d", i), 32'(bus.tick), (i == 3) ? 32'h1 : 32'h0);
    end
    bus.req = 4'b0010;
    cyc();
    chk_idle("t5_abort");
    cyc();
    chk("t5_next_gnt", 32'(bus.gnt), 32'h2);
    chk("t5_next_po", 32'(bus.po_cnt), 32'h0);
    cyc();
    chk("t5_next_tick", 32'(bus.tick), 32'h1);
    cyc();
    chk("t5_next_done", 32'(bus.done), 32'h1);
    set_cfg(2, 5, 4);
    bus.req = 4'b0100;
    cyc();
    chk("t5_dead", 32'(bus.gnt), 32'h0);
    cyc();
    chk("t5_gnt2", 32'(bus.gnt), 32'h4);
    cyc();
    chk("t5_gnt2_po", 32'(bus.po_cnt), 32'h1);

    // 6: asynchronous reset mid-run clears outputs and the RR pointer
    #2;
    rst     = 1'b1;
    bus.req = 4'b0110;
    #1;
    chk_idle("t6_async");
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_gnt", 32'(bus.gnt), 32'h2);
    chk("t6_po", 32'(bus.po_cnt), 32'h0);

    // Final tick coinciding with req drop: completion wins
    cyc();
    chk("t7_tick", 32'(bus.tick), 32'h1);
    bus.req = '0;
    cyc();
    chk("t7_done", 32'(bus.done), 32'h1);
    chk("t7_gnt", 32'(bus.gnt), 32'h2);
    cyc();
    chk_idle("t7_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div_cnt_arb
`default_nettype wire
